// File: rtl/clock_disp_pkg.sv
// rtl/clock_disp_pkg.sv - glyph constants, field-select enum and digit count for the clock display
package clock_disp_pkg;

    localparam int DIGITS = 8;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        SEL_HH   = 2'b00,
        SEL_MM   = 2'b01,
        SEL_SS   = 2'b10,
        SEL_NONE = 2'b11
    } blink_sel_e;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - time/blink inputs and segment/anode pins of the scan driver
interface seg7_scan_driver_if;
    logic [7:0] hh_bcd;
    logic [7:0] mm_bcd;
    logic [7:0] ss_bcd;
    logic       set_en;
    logic [1:0] blink_sel;
    logic [7:0] seg_out;
    logic [7:0] an_out;

    modport master (
        output hh_bcd, mm_bcd, ss_bcd, set_en, blink_sel,
        input  seg_out, an_out
    );

    modport slave (
        input  hh_bcd, mm_bcd, ss_bcd, set_en, blink_sel,
        output seg_out, an_out
    );
endinterface

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - BCD nibble to active-low g..a glyph, 'E' for non-decimal nibbles
module bcd_to_seg7
    import clock_disp_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_E;
        case (nibble_i)
            4'd0: seg_o = SEG_0;
            4'd1: seg_o = SEG_1;
            4'd2: seg_o = SEG_2;
            4'd3: seg_o = SEG_3;
            4'd4: seg_o = SEG_4;
            4'd5: seg_o = SEG_5;
            4'd6: seg_o = SEG_6;
            4'd7: seg_o = SEG_7;
            4'd8: seg_o = SEG_8;
            4'd9: seg_o = SEG_9;
            default: seg_o = SEG_E;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - 8-digit "HH-MM-SS" scan driver with field blink; HOUR_LZ_BLANK_EN blanks a leading hour zero
module seg7_scan_driver
    import clock_disp_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int SCAN_HZ  = 1_000,
    parameter int BLINK_HZ = 2
) (
    input  logic              clk_50mhz,
    input  logic              rst_n,
    seg7_scan_driver_if.slave disp
);

    localparam int SCAN_DIV   = CLK_FREQ / (SCAN_HZ * DIGITS);
    localparam int BLINK_HALF = CLK_FREQ / (2 * BLINK_HZ);
    localparam int SCAN_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BLINK_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic [2:0]         digit_q, digit_d;
    logic [7:0]         hh_q, mm_q, ss_q, hh_d, mm_d, ss_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               phase_on_q, phase_on_d;
    logic               set_en_q;
    logic [1:0]         blink_sel_q;
    logic [7:0]         seg_q, seg_d, an_q, an_d;

    logic        scan_tick, frame_load, restart, blink_wrap;
    logic [7:0]  hh_src, mm_src, ss_src;
    logic [3:0]  nib;
    logic        is_dash, blank_field, lz_blank;
    logic [6:0]  glyph;
    blink_sel_e  field, sel;

    assign sel        = blink_sel_e'(disp.blink_sel);
    assign scan_tick  = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
    assign frame_load = scan_tick && (digit_q == 3'd7);
    assign blink_wrap = (blink_cnt_q == BLINK_W'(BLINK_HALF - 1));
    assign restart    = disp.set_en && (!set_en_q || (disp.blink_sel != blink_sel_q));

    // Digit 7 renders straight from the live inputs it is snapshotting, so the whole frame matches.
    assign hh_src = frame_load ? disp.hh_bcd : hh_q;
    assign mm_src = frame_load ? disp.mm_bcd : mm_q;
    assign ss_src = frame_load ? disp.ss_bcd : ss_q;

    always_comb begin
        nib     = 4'h0;
        field   = SEL_NONE;
        is_dash = 1'b0;
        case (digit_q)
            3'd7: begin nib = hh_src[7:4]; field = SEL_HH; end
            3'd6: begin nib = hh_src[3:0]; field = SEL_HH; end
            3'd4: begin nib = mm_src[7:4]; field = SEL_MM; end
            3'd3: begin nib = mm_src[3:0]; field = SEL_MM; end
            3'd1: begin nib = ss_src[7:4]; field = SEL_SS; end
            3'd0: begin nib = ss_src[3:0]; field = SEL_SS; end
            default: is_dash = 1'b1;
        endcase
    end

    bcd_to_seg7 u_enc (
        .nibble_i (nib),
        .seg_o    (glyph)
    );

`ifdef HOUR_LZ_BLANK_EN
    assign lz_blank = (digit_q == 3'd7) && (hh_src[7:4] == 4'h0);
`else
    assign lz_blank = 1'b0;
`endif

    // Restart outranks the wrap toggle; the output path sees phase_on_d so a coincident tick uses the new phase.
    always_comb begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        phase_on_d  = phase_on_q;
        if (restart) begin
            blink_cnt_d = '0;
            phase_on_d  = 1'b1;
        end else if (blink_wrap) begin
            blink_cnt_d = '0;
            phase_on_d  = !phase_on_q;
        end
    end

    assign blank_field = disp.set_en && !phase_on_d && (field != SEL_NONE) && (field == sel);

    always_comb begin
        scan_cnt_d = scan_tick ? '0 : scan_cnt_q + SCAN_W'(1);
        digit_d    = scan_tick ? digit_q - 3'd1 : digit_q;
        hh_d       = frame_load ? disp.hh_bcd : hh_q;
        mm_d       = frame_load ? disp.mm_bcd : mm_q;
        ss_d       = frame_load ? disp.ss_bcd : ss_q;
        seg_d      = seg_q;
        an_d       = an_q;
        if (scan_tick) begin
            an_d = ~(8'b1 << digit_q);
            if (blank_field || lz_blank)
                seg_d = 8'hFF;
            else
                seg_d = {1'b1, is_dash ? SEG_DASH : glyph};
        end
    end

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q  <= '0;
            digit_q     <= 3'd7;
            hh_q        <= 8'h00;
            mm_q        <= 8'h00;
            ss_q        <= 8'h00;
            blink_cnt_q <= '0;
            phase_on_q  <= 1'b1;
            set_en_q    <= 1'b0;
            blink_sel_q <= SEL_NONE;
            seg_q       <= 8'hFF;
            an_q        <= 8'hFF;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            digit_q     <= digit_d;
            hh_q        <= hh_d;
            mm_q        <= mm_d;
            ss_q        <= ss_d;
            blink_cnt_q <= blink_cnt_d;
            phase_on_q  <= phase_on_d;
            set_en_q    <= disp.set_en;
            blink_sel_q <= disp.blink_sel;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    assign disp.seg_out = seg_q;
    assign disp.an_out  = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg7_scan_driver_if dif();

    seg7_scan_driver #(.CLK_FREQ(800), .SCAN_HZ(10), .BLINK_HZ(2)) dut (
        .clk_50mhz (clk),
        .rst_n     (rst_n),
        .disp      (dif)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [7:0] prev_an = 8'hFF;
    logic [7:0] snap_hh = 8'h00, snap_mm = 8'h00, snap_ss = 8'h00;
    int last_d = 7;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int digit_of(logic [7:0] an);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] one_cold;
            one_cold = ~(8'b1 << i);
            if (an == one_cold) return i;
        end
        return -1;
    endfunction

    function automatic int field_of(int d);
        if (d == 7 || d == 6) return 0;
        if (d == 4 || d == 3) return 1;
        if (d == 1 || d == 0) return 2;
        return 3;
    endfunction

    function automatic logic [7:0] glyph(logic [3:0] n);
        case (n)
            4'd0: return 8'hC0;
            4'd1: return 8'hF9;
            4'd2: return 8'hA4;
            4'd3: return 8'hB0;
            4'd4: return 8'h99;
            4'd5: return 8'h92;
            4'd6: return 8'h82;
            4'd7: return 8'hF8;
            4'd8: return 8'h80;
            4'd9: return 8'h90;
            default: return 8'h86;
        endcase
    endfunction

    function automatic logic [7:0] model_seg(int d, logic [7:0] hh, logic [7:0] mm, logic [7:0] ss, bit blank);
        logic [3:0] n;
        if (blank) return 8'hFF;
        case (d)
            7: n = hh[7:4];
            6: n = hh[3:0];
            4: n = mm[7:4];
            3: n = mm[3:0];
            1: n = ss[7:4];
            0: n = ss[3:0];
            default: return 8'hBF;
        endcase
`ifdef HOUR_LZ_BLANK_EN
        if (d == 7 && n == 4'h0) return 8'hFF;
`endif
        return glyph(n);
    endfunction

    // Waits for the next anode change; n is the posedge count at which the new value was loaded.
    task automatic wait_tick(output int n, output bit to);
        bit got;
        got = 1'b0;
        n = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (dif.an_out !== prev_an) begin
                prev_an = dif.an_out;
                n = cyc;
                got = 1'b1;
            end
        end
        to = !got;
    endtask

    task automatic test_reset();
        int n, pn, t_rel, d;
        bit to;
        rst_n = 1'b0;
        dif.hh_bcd = 8'h00; dif.mm_bcd = 8'h00; dif.ss_bcd = 8'h00;
        dif.set_en = 1'b0; dif.blink_sel = 2'b11;
        repeat (3) @(negedge clk);
        checks++;
        if (dif.seg_out !== 8'hFF) begin failures++; $display("FAIL reset_seg got=%h exp=ff", dif.seg_out); end
        checks++;
        if (dif.an_out !== 8'hFF) begin failures++; $display("FAIL reset_an got=%h exp=ff", dif.an_out); end
        prev_an = 8'hFF;
        rst_n = 1'b1;
        t_rel = cyc;
        pn = t_rel;
        for (int k = 0; k < 9; k++) begin
            wait_tick(n, to);
            checks++;
            if (to) begin failures++; $display("FAIL reset_tick_timeout k=%0d", k); break; end
            d = digit_of(prev_an);
            if (d == 7) begin snap_hh = dif.hh_bcd; snap_mm = dif.mm_bcd; snap_ss = dif.ss_bcd; end
            if ((n - pn) !== 10 || d !== ((7 - k + 8) % 8)) begin
                failures++;
                $display("FAIL reset_scan k=%0d got_gap=%0d got_an=%h exp_gap=10 exp_digit=%0d", k, n - pn, prev_an, (7 - k + 8) % 8);
            end
            checks++;
            if (dif.seg_out !== model_seg(d, snap_hh, snap_mm, snap_ss, 1'b0)) begin
                failures++;
                $display("FAIL reset_seg_frame d=%0d got=%h exp=%h", d, dif.seg_out, model_seg(d, snap_hh, snap_mm, snap_ss, 1'b0));
            end
            pn = n;
            last_d = d;
        end
    endtask

    task automatic test_frame();
        int n, d;
        bit to;
        dif.hh_bcd = 8'h16; dif.mm_bcd = 8'h25; dif.ss_bcd = 8'h03;
        for (int k = 0; k < 100; k++) begin
            wait_tick(n, to);
            checks++;
            if (to) begin failures++; $display("FAIL frame_timeout k=%0d", k); break; end
            d = digit_of(prev_an);
            if (d == 7) begin snap_hh = dif.hh_bcd; snap_mm = dif.mm_bcd; snap_ss = dif.ss_bcd; end
            if (d !== (last_d + 7) % 8) begin
                failures++; $display("FAIL frame_digit got=%0d exp=%0d", d, (last_d + 7) % 8);
            end
            checks++;
            if (dif.seg_out !== model_seg(d, snap_hh, snap_mm, snap_ss, 1'b0)) begin
                failures++;
                $display("FAIL frame_seg d=%0d got=%h exp=%h", d, dif.seg_out, model_seg(d, snap_hh, snap_mm, snap_ss, 1'b0));
            end
            last_d = d;
        end
    endtask

    task automatic test_capture();
        int n, d;
        bit to, changed, seen7;
        changed = 1'b0;
        seen7 = 1'b0;
        for (int k = 0; k < 30; k++) begin
            wait_tick(n, to);
            checks++;
            if (to) begin failures++; $display("FAIL capture_timeout k=%0d", k); break; end
            d = digit_of(prev_an);
            if (d == 7) begin snap_hh = dif.hh_bcd; snap_mm = dif.mm_bcd; snap_ss = dif.ss_bcd; end
            if (dif.seg_out !== model_seg(d, snap_hh, snap_mm, snap_ss, 1'b0)) begin
                failures++;
                $display("FAIL capture_seg d=%0d got=%h exp=%h", d, dif.seg_out, model_seg(d, snap_hh, snap_mm, snap_ss, 1'b0));
            end
            if (changed && d == 7) seen7 = 1'b1;
            if (changed && !seen7 && d < 4) begin
                checks++;
                if (snap_hh !== 8'h16) begin failures++; $display("FAIL capture_tear snap=%h exp=16", snap_hh); end
            end
            if (seen7 && d == 6) begin
                checks++;
                if (dif.seg_out !== 8'h80) begin failures++; $display("FAIL capture_new_frame got=%h exp=80", dif.seg_out); end
                last_d = d;
                break;
            end
            if (!changed && d == 4) begin
                dif.hh_bcd = 8'h18;
                changed = 1'b1;
            end
            last_d = d;
        end
    endtask

    task automatic test_blink();
        int n, d, e0, k, sel;
        bit to, blank, switched, saw_off;
        saw_off = 1'b0;
        switched = 1'b0;
        dif.set_en = 1'b1;
        dif.blink_sel = 2'b01;
        sel = 1;
        e0 = cyc + 1;
        for (int t = 0; t < 140; t++) begin
            wait_tick(n, to);
            checks++;
            if (to) begin failures++; $display("FAIL blink_timeout t=%0d", t); break; end
            d = digit_of(prev_an);
            k = n - e0;
            blank = (field_of(d) == sel) && (((k / 200) % 2) == 1);
            if (blank) saw_off = 1'b1;
            if (dif.seg_out !== model_seg(d, snap_hh, snap_mm, snap_ss, blank)) begin
                failures++;
                $display("FAIL blink_seg sel=%0d d=%0d k=%0d got=%h exp=%h", sel, d, k, dif.seg_out, model_seg(d, snap_hh, snap_mm, snap_ss, blank));
            end
            checks++;
            if (d !== (last_d + 7) % 8) begin failures++; $display("FAIL blink_an got=%h exp_digit=%0d", prev_an, (last_d + 7) % 8); end
            last_d = d;
            if (!switched && k >= 250) begin
                dif.blink_sel = 2'b10;
                sel = 2;
                e0 = cyc + 1;
                switched = 1'b1;
            end
        end
        checks++;
        if (!saw_off) begin failures++; $display("FAIL blink_off_seen got=0 exp=1"); end
        dif.set_en = 1'b0;
        dif.blink_sel = 2'b11;
    endtask

    task automatic test_encode();
        int n, d;
        bit to, seen7;
        seen7 = 1'b0;
        dif.hh_bcd = 8'h09; dif.mm_bcd = 8'h25; dif.ss_bcd = 8'h3C;
        for (int k = 0; k < 20; k++) begin
            wait_tick(n, to);
            checks++;
            if (to) begin failures++; $display("FAIL encode_timeout k=%0d", k); break; end
            d = digit_of(prev_an);
            if (d == 7) begin snap_hh = dif.hh_bcd; snap_mm = dif.mm_bcd; snap_ss = dif.ss_bcd; seen7 = 1'b1; end
            if (dif.seg_out !== model_seg(d, snap_hh, snap_mm, snap_ss, 1'b0)) begin
                failures++;
                $display("FAIL encode_seg d=%0d got=%h exp=%h", d, dif.seg_out, model_seg(d, snap_hh, snap_mm, snap_ss, 1'b0));
            end
            if (seen7 && d == 7) begin
                checks++;
`ifdef HOUR_LZ_BLANK_EN
                if (dif.seg_out !== 8'hFF) begin failures++; $display("FAIL encode_lz got=%h exp=ff", dif.seg_out); end
`else
                if (dif.seg_out !== 8'hC0) begin failures++; $display("FAIL encode_lz got=%h exp=c0", dif.seg_out); end
`endif
            end
            last_d = d;
            if (seen7 && d == 0) begin
                checks++;
                if (dif.seg_out !== 8'h86) begin failures++; $display("FAIL encode_E got=%h exp=86", dif.seg_out); end
                break;
            end
        end
    endtask

    task automatic test_reset_mid();
        int n, d, t_rel;
        bit to, hit;
        hit = 1'b0;
        for (int k = 0; k < 12 && !hit; k++) begin
            wait_tick(n, to);
            if (to) begin checks++; failures++; $display("FAIL midrst_timeout k=%0d", k); break; end
            d = digit_of(prev_an);
            if (d == 3) hit = 1'b1;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dif.seg_out !== 8'hFF || dif.an_out !== 8'hFF) begin
            failures++; $display("FAIL midrst_async got_seg=%h got_an=%h exp=ff/ff", dif.seg_out, dif.an_out);
        end
        prev_an = 8'hFF;
        @(negedge clk);
        rst_n = 1'b1;
        t_rel = cyc;
        wait_tick(n, to);
        checks++;
        if (to || (n - t_rel) !== 10 || prev_an !== 8'h7F) begin
            failures++; $display("FAIL midrst_restart got_gap=%0d got_an=%h exp_gap=10 exp_an=7f", n - t_rel, prev_an);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_capture();
        test_blink();
        test_encode();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
